// File: rtl/digit_scan_sequencer.sv
// rtl/digit_scan_sequencer.sv - four-digit scan sequencer feeding a 2-to-4 enable decoder
// Blanks before each digit; double-buffers digit data so new values land at frame boundaries.
module digit_scan_sequencer #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic [3:0]  mask,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        frame_done,
    output logic        load_pend
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       hold_q, hold_d;
    logic              load_pend_q, load_pend_d;
    logic              frame_done_q, frame_done_d;
    logic              boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'd0;
            hold_q       <= 16'd0;
            load_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            hold_q       <= hold_d;
            load_pend_q  <= load_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Last SHOW cycle of digit 3 while still scanning: the only point shadow may change mid-scan.
    assign boundary = (state_q == SHOW) && (sel_q == 2'd3) && (cnt_q == DWELL_LAST) && run;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = BLANK;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (!run) begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d      = BLANK;
                    cnt_d        = '0;
                    sel_d        = sel_q + 2'd1;
                    frame_done_d = (sel_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        shadow_d    = shadow_q;
        hold_d      = hold_q;
        load_pend_d = load_pend_q;

        if (state_q == IDLE) begin
            // Nothing is displayed, so a load goes straight to the shadow and supersedes any stale hold.
            if (load) begin
                shadow_d    = digits;
                load_pend_d = 1'b0;
            end
        end else if (boundary && (load || load_pend_q)) begin
            shadow_d    = load ? digits : hold_q;
            load_pend_d = 1'b0;
        end else if (load) begin
            hold_d      = digits;
            load_pend_d = 1'b1;
        end
    end

    assign sel        = sel_q;
    assign sel_en     = (state_q == SHOW) && mask[sel_q];
    assign nibble     = shadow_q[{sel_q, 2'b00} +: 4];
    assign frame_done = frame_done_q;
    assign load_pend  = load_pend_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// tb/tb_digit_scan_sequencer.sv - directed self-checking bench for digit_scan_sequencer
// Slot = 2 blank + 4 show cycles; frame = 24 cycles indexed c = 0..23 from first BLANK of digit 0.
module tb_digit_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] digits;
    logic        load;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic        sel_en;
    logic [3:0]  nibble;
    logic        frame_done;
    logic        load_pend;

    int checks;
    int errors;

    logic [15:0] exp_shadow;
    logic [15:0] exp_hold;
    logic        exp_pend;

    digit_scan_sequencer #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .digits(digits),
        .load(load),
        .mask(mask),
        .sel(sel),
        .sel_en(sel_en),
        .nibble(nibble),
        .frame_done(frame_done),
        .load_pend(load_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock while scanning, updating the expected double-buffer state first.
    task automatic step(input int c);
        if (run && c == 23 && (exp_pend || load)) begin
            exp_shadow = load ? digits : exp_hold;
            exp_pend   = 1'b0;
        end else if (run && load) begin
            exp_hold = digits;
            exp_pend = 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_cycle(input string tag, input int c, input logic fd_exp);
        logic [15:0] sh;
        sh = exp_shadow;
        chk({tag, " sel"},        32'(sel),        32'(c / 6));
        chk({tag, " sel_en"},     32'(sel_en),     32'((c % 6 >= 2) && mask[c / 6]));
        chk({tag, " nibble"},     32'(nibble),     32'(sh[4 * (c / 6) +: 4]));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(c == 0 && fd_exp));
        chk({tag, " load_pend"},  32'(load_pend),  32'(exp_pend));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_shadow = 16'h0000;
        exp_hold   = 16'h0000;
        exp_pend   = 1'b0;
        rst        = 1'b1;
        run        = 1'b0;
        digits     = 16'h0000;
        load       = 1'b0;
        mask       = 4'b1111;

        #3;
        chk("reset sel",        32'(sel),        32'd0);
        chk("reset sel_en",     32'(sel_en),     32'd0);
        chk("reset nibble",     32'(nibble),     32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset load_pend",  32'(load_pend),  32'd0);

        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Load while idle goes straight to the shadow.
        digits = 16'h4321;
        load   = 1'b1;
        @(posedge clk);
        #2;
        load       = 1'b0;
        exp_shadow = 16'h4321;
        chk("idle load nibble",    32'(nibble),    32'h1);
        chk("idle load load_pend", 32'(load_pend), 32'd0);
        chk("idle sel_en",         32'(sel_en),    32'd0);

        run = 1'b1;
        @(posedge clk);
        #2;

        // Frame A: full mask, ABCD loaded during SHOW of digit 1 stays pending.
        for (int c = 0; c < 24; c++) begin
            check_cycle("frameA", c, 1'b0);
            if (c == 8) begin
                digits = 16'hABCD;
                load   = 1'b1;
            end
            step(c);
            load = 1'b0;
        end

        // Frame B: ABCD now visible, first frame_done pulse.
        for (int c = 0; c < 24; c++) begin
            check_cycle("frameB", c, 1'b1);
            step(c);
        end

        // Frame C: sparse mask, load exactly on the boundary cycle.
        mask = 4'b0101;
        for (int c = 0; c < 24; c++) begin
            check_cycle("frameC", c, 1'b1);
            if (c == 23) begin
                digits = 16'h00F0;
                load   = 1'b1;
            end
            step(c);
            load = 1'b0;
        end

        // Frame D: boundary load applied immediately; drop run mid-SHOW of digit 1.
        mask = 4'b1111;
        for (int c = 0; c <= 8; c++) begin
            check_cycle("frameD", c, 1'b1);
            if (c == 8) run = 1'b0;
            step(c);
        end
        for (int i = 0; i < 3; i++) begin
            chk("stop sel",        32'(sel),        32'd0);
            chk("stop sel_en",     32'(sel_en),     32'd0);
            chk("stop frame_done", 32'(frame_done), 32'd0);
            chk("stop nibble",     32'(nibble),     32'h0);
            @(posedge clk);
            #2;
        end

        // Restart: two blank cycles then digit 0, with a pending load cut off by reset.
        run = 1'b1;
        @(posedge clk);
        #2;
        for (int c = 0; c <= 14; c++) begin
            check_cycle("restart", c, 1'b0);
            if (c == 8) begin
                digits = 16'h1234;
                load   = 1'b1;
            end
            if (c < 14) begin
                step(c);
                load = 1'b0;
            end
        end

        rst = 1'b1;
        #1;
        chk("midrst sel",        32'(sel),        32'd0);
        chk("midrst sel_en",     32'(sel_en),     32'd0);
        chk("midrst nibble",     32'(nibble),     32'd0);
        chk("midrst frame_done", 32'(frame_done), 32'd0);
        chk("midrst load_pend",  32'(load_pend),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        #2;
        chk("post rst sel_en",    32'(sel_en),    32'd0);
        chk("post rst load_pend", 32'(load_pend), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
